// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared constants and helpers
// for the register-file access arbiter.
package regfile_arb_pkg;

    localparam int ADDR_W    = 6;
    localparam int IDX_W     = 3;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NREQ  = 4;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [7:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick starting at i_ptr,
// returns one-hot grant and the winner index.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
)(
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [NREQ-1:0] w_bit;
    logic [7:0]      w_pad;

    // scan downward so the requester closest to ptr wins last
    always_comb begin
        o_gnt = '0;
        w_bit = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_bit = NREQ'(1) << ((int'(i_ptr) + k) % NREQ);
            if ((i_req & w_bit) != '0) o_gnt = w_bit;
        end
    end

    // widen the grant for the shared index helper
    always_comb begin
        w_pad = '0;
        w_pad[NREQ-1:0] = o_gnt;
    end

    assign o_idx = onehot_to_idx(w_pad);
    assign o_any = |o_gnt;

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one register-file port among NREQ requesters.
// Optional macro REGFILE_ARB_LOCK_EN adds a lock input for re-grants.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NREQ  = DEF_NREQ
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]  req_wdata,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [NREQ-1:0]        lock,
`endif
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [WIDTH-1:0]       rdata,
    output logic                   err,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_select,
    output logic [WIDTH-1:0]       rf_write_data,
    input  logic [WIDTH-1:0]       rf_read_out
);

    logic [IDX_W-1:0]  r_ptr;
    logic [NREQ-1:0]   r_rvalid;
    logic [WIDTH-1:0]  r_rdata;
    logic              r_err;

    logic [NREQ-1:0]   w_rr_gnt;
    logic [IDX_W-1:0]  w_rr_idx;
    logic              w_rr_any;
    logic [NREQ-1:0]   w_gnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_hold;
    logic              w_any;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  w_wdata;
    logic              w_oor;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

`ifdef REGFILE_ARB_LOCK_EN
    logic             r_last_v;
    logic [IDX_W-1:0] r_last_idx;
    logic [NREQ-1:0]  w_last_oh;

    assign w_last_oh = NREQ'(1) << r_last_idx;
    assign w_hold    = r_last_v && ((w_last_oh & lock & req) != '0);

    // remember last cycle's winner for a locked re-grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_v   <= 1'b0;
            r_last_idx <= '0;
        end else begin
            r_last_v   <= w_any;
            r_last_idx <= w_idx;
        end
    end

    // a locked owner bypasses round-robin order
    always_comb begin
        w_gnt = w_hold ? w_last_oh : w_rr_gnt;
        w_idx = w_hold ? r_last_idx : w_rr_idx;
    end
`else
    assign w_hold = 1'b0;
    assign w_gnt  = w_rr_gnt;
    assign w_idx  = w_rr_idx;
`endif

    assign w_any   = (w_hold | w_rr_any) & ~rst;
    assign w_we    = |(req_we & w_gnt);
    assign w_addr  = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
    assign w_wdata = req_wdata[int'(w_idx)*WIDTH +: WIDTH];
    assign w_oor   = int'(w_addr) >= DEPTH;

    assign gnt           = w_any ? w_gnt : '0;
    assign rf_we         = w_any & w_we & ~w_oor;
    assign rf_select     = w_any ? w_addr : '0;
    assign rf_write_data = w_any ? w_wdata : '0;

    // advance the pointer past each round-robin winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any && !w_hold) begin
            r_ptr <= (w_idx == IDX_W'(NREQ - 1)) ? '0 : w_idx + IDX_W'(1);
        end
    end

    // return read data and the range error one cycle after grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= (w_any && !w_we) ? w_gnt : '0;
            r_err    <= w_any & w_oor;
            if (w_any && !w_we) r_rdata <= w_oor ? '0 : rf_read_out;
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign err    = r_err;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: random and directed traffic checked
// against a behavioural model of the arbiter.
module tb_regfile_arbiter;

    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int NREQ  = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*6-1:0] req_addr;
    logic [NREQ*W-1:0] req_wdata;
    logic [NREQ-1:0]   lock;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rvalid;
    logic [W-1:0]      rdata;
    logic              err;
    logic              rf_we;
    logic [5:0]        rf_select;
    logic [W-1:0]      rf_write_data;
    logic [W-1:0]      rf_read_out;

    int n_checks = 0;
    int n_errors = 0;

    regfile_arbiter #(.WIDTH(W), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
`ifdef REGFILE_ARB_LOCK_EN
        .lock          (lock),
`endif
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .err           (err),
        .rf_we         (rf_we),
        .rf_select     (rf_select),
        .rf_write_data (rf_write_data),
        .rf_read_out   (rf_read_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // environment register file
    logic [W-1:0] rf_mem [DEPTH];
    assign rf_read_out = (rf_select < 6'(DEPTH)) ? rf_mem[rf_select[4:0]] : 32'hBAD0BAD0;
    always @(posedge clk)
        if (rf_we && rf_select < 6'(DEPTH)) rf_mem[rf_select[4:0]] <= rf_write_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // behavioural model state
    int              m_ptr;
    int              m_last;
    logic [W-1:0]    m_mem [DEPTH];
    logic [NREQ-1:0] m_rvalid;
    logic [W-1:0]    m_rdata;
    logic            m_err;
    logic [NREQ-1:0] last_gnt = '0;

    always @(negedge clk) begin
        int w;
        int a;
        bit we_b;
        bit hold;
        logic [NREQ-1:0] eg;
        if (rst) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_rf_we", rf_we, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_err", err, 0);
            m_ptr = 0; m_last = -1;
            m_rvalid = '0; m_rdata = '0; m_err = 1'b0;
            last_gnt = '0;
        end else begin
            chk("rvalid", rvalid, m_rvalid);
            chk("rdata", rdata, m_rdata);
            chk("err", err, m_err);
            w = -1;
            hold = 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
            if (m_last >= 0 && lock[m_last] && req[m_last]) begin
                w = m_last;
                hold = 1'b1;
            end
`endif
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            eg = (w >= 0) ? NREQ'(1) << w : '0;
            chk("gnt", gnt, eg);
            if (w < 0) begin
                chk("idle_sel", rf_select, 0);
                chk("idle_we", rf_we, 0);
                m_rvalid = '0;
                m_err = 1'b0;
            end else begin
                a = int'(req_addr[w*6 +: 6]);
                we_b = req_we[w];
                chk("sel", rf_select, a);
                chk("rf_we", rf_we, we_b && a < DEPTH);
                chk("wdata", rf_write_data, req_wdata[w*W +: W]);
                if (we_b) begin
                    if (a < DEPTH) m_mem[a] = req_wdata[w*W +: W];
                    m_rvalid = '0;
                end else begin
                    m_rvalid = eg;
                    m_rdata = (a < DEPTH) ? m_mem[a] : '0;
                end
                m_err = (a >= DEPTH);
                if (!hold) m_ptr = (w + 1) % NREQ;
            end
            m_last = w;
            last_gnt = eg;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit we, input int addr, input logic [W-1:0] d);
        req[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*6 +: 6] = 6'(addr);
        req_wdata[i*W +: W] = d;
    endtask

    logic [W-1:0] snap [DEPTH];
    int diffs;

    initial begin
        rst = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0; lock = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rf_mem[i] = '0;
            m_mem[i] = '0;
        end
        repeat (2) tick();
        chk("lit_rst_gnt", gnt, 0);
        chk("lit_rst_rdata", rdata, 0);
        rst = 1'b0;

        // single write by requester 2
        set_req(2, 1'b1, 5, 32'hDEADBEEF);
        @(negedge clk);
        chk("lit_wr_gnt", gnt, 4'b0100);
        chk("lit_wr_we", rf_we, 1);
        chk("lit_wr_sel", rf_select, 5);
        tick();
        req = '0;
        chk("lit_wr_mem", rf_mem[5], 32'hDEADBEEF);

        // read-back by requester 1
        set_req(1, 1'b0, 5, '0);
        @(negedge clk);
        chk("lit_rd_gnt", gnt, 4'b0010);
        tick();
        req = '0;
        @(negedge clk);
        chk("lit_rd_rvalid", rvalid, 4'b0010);
        chk("lit_rd_rdata", rdata, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("lit_rvalid_drop", rvalid, 0);
        chk("lit_rdata_hold", rdata, 32'hDEADBEEF);

        // out-of-range write then read
        for (int i = 0; i < DEPTH; i++) snap[i] = rf_mem[i];
        set_req(0, 1'b1, 40, 32'h12345678);
        @(negedge clk);
        chk("lit_oor_gnt", gnt, 4'b0001);
        chk("lit_oor_we", rf_we, 0);
        tick();
        req = '0;
        @(negedge clk);
        chk("lit_oor_err", err, 1);
        tick();
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (rf_mem[i] !== snap[i]) diffs++;
        chk("lit_oor_mem", diffs, 0);
        set_req(2, 1'b0, 50, '0);
        @(negedge clk);
        chk("lit_oor_rd_gnt", gnt, 4'b0100);
        tick();
        req = '0;
        @(negedge clk);
        chk("lit_oor_rd_rvalid", rvalid, 4'b0100);
        chk("lit_oor_rd_rdata", rdata, 0);
        chk("lit_oor_rd_err", err, 1);
        tick();

        // reset asserted in the grant cycle of a read
        set_req(3, 1'b0, 5, '0);
        #2 rst = 1'b1;
        tick();
        @(negedge clk);
        chk("lit_rstrd_rvalid", rvalid, 0);
        chk("lit_rstrd_rdata", rdata, 0);
        req = '0;
        set_req(1, 1'b0, 2, '0);
        set_req(3, 1'b0, 3, '0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_post_rst_gnt", gnt, 4'b0010);
        tick();

        // fairness: all requesters read continuously from reset
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, i, '0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lit_fair_gnt", gnt, 4'b0001 << (k % 4));
            chk("lit_fair_onehot", $countones(gnt), 1);
            tick();
        end
        req = '0;
        tick();

`ifdef REGFILE_ARB_LOCK_EN
        // locked requester 3 keeps the port while 0 waits
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 1, '0);
        @(negedge clk);
        chk("lit_lock_pre", gnt, 4'b0001);
        tick();
        set_req(3, 1'b0, 2, '0);
        lock = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lit_lock_gnt", gnt, 4'b1000);
            tick();
        end
        req[3] = 1'b0;
        lock = '0;
        @(negedge clk);
        chk("lit_lock_after", gnt, 4'b0001);
        tick();
        req = '0;
`endif

        // randomized traffic with withdrawals and range errors
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_gnt[i] || !req[i]) begin
                    req[i] = 1'b0;
                    if ($urandom_range(0, 2) != 0) begin
                        if ($urandom_range(0, 9) == 0)
                            set_req(i, 1'($urandom_range(0, 1)),
                                    $urandom_range(32, 63), $urandom);
                        else
                            set_req(i, 1'($urandom_range(0, 1)),
                                    $urandom_range(0, 7), $urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            lock = NREQ'($urandom);
            if (c == 1000) rst = 1'b1;
            if (c == 1002) rst = 1'b0;
            tick();
        end
        req = '0;
        lock = '0;
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of the shared register file.
REQ-002 Parameter DEPTH, default 32, number of register-file entries; legal range 1..64.
REQ-003 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NREQ  per-requester access request, held high until granted.
REQ-007 req_we  input  NREQ  per-requester access type: 1 = write, 0 = read.
REQ-008 req_addr  input  NREQ*6  per-requester register index; slice i = bits [6i+5:6i].
REQ-009 req_wdata  input  NREQ*WIDTH  per-requester write data; slice i = bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-010 gnt  output  NREQ  one-hot grant; the access is accepted in the cycle gnt[i] is high.
REQ-011 rvalid  output  NREQ  one-hot, one-cycle read-return strobe.
REQ-012 rdata  output  WIDTH  read-return data, qualified by rvalid.
REQ-013 err  output  1  one-cycle strobe flagging an out-of-range access.
REQ-014 rf_we, rf_select[5:0], rf_write_data[WIDTH-1:0]  outputs  drive the register file's write enable, index and write data.
REQ-015 rf_read_out  input  WIDTH  combinational read data returned by the register file for rf_select.

Function
REQ-016 At most one gnt bit SHALL be high per cycle; gnt SHALL be combinational from req and the priority pointer.
REQ-017 Arbitration SHALL be round-robin: search starts at pointer ptr and proceeds upward modulo NREQ; the first requester with req high wins.
REQ-018 After a grant to requester w, ptr SHALL become (w+1) mod NREQ at the next edge; with no grant, ptr SHALL hold.
REQ-019 In a grant cycle, rf_select SHALL equal the winner's address, and rf_write_data SHALL equal the winner's wdata.
REQ-020 In a grant cycle, rf_we SHALL equal the winner's req_we; rf_we SHALL be 0 in every other cycle.
REQ-021 A write SHALL take effect in the register file at the edge that ends the grant cycle.
REQ-022 A read granted in cycle N SHALL capture rf_read_out into rdata at the end of N; rvalid[w] SHALL be high during N+1 only (latency 1).
REQ-023 rdata SHALL hold its last value when no rvalid bit is high.
REQ-024 When the winner's address is >= DEPTH, the grant SHALL still be issued but rf_we SHALL be forced to 0.
REQ-025 For such an out-of-range read, rdata SHALL be 0 in cycle N+1 while rvalid still pulses.
REQ-026 For any out-of-range access, err SHALL pulse in cycle N+1.
REQ-027 A requester that drops req before being granted SHALL be treated as withdrawn, with no side effects.
REQ-028 Back-to-back grants to different requesters SHALL be sustained at one access per cycle.
REQ-029 When no grant is issued, rf_select SHALL be 0.

Reset
REQ-030 While rst is high: ptr = 0, rvalid = 0, rdata = 0, err = 0, gnt = 0 and rf_we = 0, independent of clk.
REQ-031 A read granted in the cycle rst asserts SHALL produce no rvalid; arbitration SHALL resume with ptr = 0 on the first edge after release.

Configuration
REQ-032 Macro REGFILE_ARB_LOCK_EN, when defined, SHALL add input lock[NREQ-1:0].
REQ-033 With the macro defined, if the requester granted last cycle has both lock and req high, it SHALL be granted again regardless of round-robin order, and ptr SHALL not advance.
REQ-034 Without the macro, the lock port and its logic SHALL be absent, and behaviour SHALL be pure round-robin.

Structure
REQ-035 Package regfile_arb_pkg SHALL hold ADDR_W = 6, the default WIDTH/DEPTH/NREQ constants and the one-hot-to-index function.
REQ-036 Sub-module rr_arbiter (req, ptr -> one-hot gnt, winner index) SHALL hold the arbitration; regfile_arbiter SHALL hold ptr, the read-return registers and the err logic.

Verification
REQ-037 Single write: requester 2 writes addr 5, data 0xDEADBEEF -> gnt[2] and rf_we high for one cycle, rf_select = 5.
REQ-038 Read-back: requester 1 then reads addr 5 -> rvalid[1] one cycle after gnt[1], rdata = 0xDEADBEEF.
REQ-039 Fairness: all 4 requesters read continuously from reset -> grants in order 0,1,2,3,0, one per cycle, never two bits high.
REQ-040 Out of range: requester 0 writes addr 40 with DEPTH = 32 -> gnt[0] high, rf_we low, err pulses in the next cycle, entry contents unchanged.
REQ-041 Reset mid-read: rst asserted in the grant cycle of a read -> rvalid stays 0, rdata = 0, first post-reset grant goes to the lowest requesting index.
REQ-042 With REGFILE_ARB_LOCK_EN: requester 3 holds lock and req for 3 cycles while 0 also requests -> gnt[3] for 3 consecutive cycles, then gnt[0].
